// File: rtl/dma_pkg.sv
// dma_pkg: shared types and helpers for the DMA copy engine.
package dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } dma_state_e;

   // Byte distance between consecutive words on the bus.
   localparam int unsigned WORD_STRIDE = 2;

   // Addresses must be word aligned; bit 0 set on either side is an error.
   function automatic logic addr_misaligned(input logic src_lsb, input logic dst_lsb);
      return src_lsb | dst_lsb;
   endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: source/destination pointers and remaining word count.
// On load the pointers start at the base (ascending) or at base+2*(len-1)
// (descending); each step moves both pointers one word and decrements count.
module dma_addr_gen
   import dma_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              dir_down,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [LEN_W-1:0]  len,
   output logic [ADDR_W-1:0] src_ptr,
   output logic [ADDR_W-1:0] dst_ptr,
   output logic [LEN_W-1:0]  count
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

   logic              down_q;
   logic [LEN_W-1:0]  len_m1;
   logic [ADDR_W-1:0] start_off;

   // Byte offset of the last word; only used when copying downwards.
   assign len_m1    = len - LEN_W'(1);
   assign start_off = dir_down ? ADDR_W'({len_m1, 1'b0}) : '0;

   // Pointer/count registers; arithmetic wraps modulo 2^ADDR_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_ptr <= '0;
         dst_ptr <= '0;
         count   <= '0;
         down_q  <= 1'b0;
      end else if (load) begin
         src_ptr <= src_base + start_off;
         dst_ptr <= dst_base + start_off;
         count   <= len;
         down_q  <= dir_down;
      end else if (step) begin
         src_ptr <= down_q ? src_ptr - STRIDE : src_ptr + STRIDE;
         dst_ptr <= down_q ? dst_ptr - STRIDE : dst_ptr + STRIDE;
         count   <= count - LEN_W'(1);
      end
   end

endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-by-word memory copy, one read then one write per word.
// Optional feature: define DMA_COPY_OVERLAP_EN to copy overlapping regions
// top-down (memmove semantics) when the destination lies above the source.
module dma_copy_engine
   import dma_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_read_data
);

   dma_state_e        state, state_nxt;
   logic [DATA_W-1:0] data_q;
   logic              err_q;
   logic              load, step, dir_down, misaligned;
   logic [ADDR_W-1:0] src_ptr, dst_ptr;
   logic [LEN_W-1:0]  count;

   assign misaligned = addr_misaligned(src_addr[0], dst_addr[0]);
   assign step       = (state == ST_WRITE);

`ifdef DMA_COPY_OVERLAP_EN
   localparam int EXT_W = ADDR_W + LEN_W + 1;
   logic [EXT_W-1:0] src_ext, dst_ext, src_end;

   // Overlap test in widened arithmetic so src+2*len cannot wrap.
   assign src_ext  = EXT_W'(src_addr);
   assign dst_ext  = EXT_W'(dst_addr);
   assign src_end  = src_ext + EXT_W'({len, 1'b0});
   assign dir_down = (dst_ext > src_ext) && (dst_ext < src_end);
`else
   assign dir_down = 1'b0;
`endif

   dma_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .dir_down (dir_down),
      .src_base (src_addr),
      .dst_base (dst_addr),
      .len      (len),
      .src_ptr  (src_ptr),
      .dst_ptr  (dst_ptr),
      .count    (count)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and pointer load request.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !misaligned) begin
               if (len == '0) begin
                  state_nxt = ST_DONE;
               end else begin
                  load      = 1'b1;
                  state_nxt = ST_READ;
               end
            end
         end
         ST_READ:  state_nxt = abort ? ST_IDLE : ST_WRITE;
         // The write of this cycle still happens on abort; only the loop ends.
         ST_WRITE: begin
            if (abort)                      state_nxt = ST_IDLE;
            else if (count == LEN_W'(1))    state_nxt = ST_DONE;
            else                            state_nxt = ST_READ;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Word buffer between the read and write halves of each transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   data_q <= '0;
      else if (state == ST_READ) data_q <= mem_read_data;
   end

   // One-cycle error flag for a misaligned request seen in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= (state == ST_IDLE) && start && misaligned;
   end

   assign busy            = (state == ST_READ) || (state == ST_WRITE);
   assign done            = (state == ST_DONE);
   assign err             = err_q;
   assign mem_read        = (state == ST_READ);
   assign mem_write_en    = (state == ST_WRITE);
   assign mem_access_addr = (state == ST_READ)  ? src_ptr :
                            (state == ST_WRITE) ? dst_ptr : '0;
   assign mem_write_data  = (state == ST_WRITE) ? data_q : '0;

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16: byte-address width of the memory bus.
REQ-002 The block SHALL have parameter DATA_W, default 16: word width of the memory bus.
REQ-003 The block SHALL have parameter LEN_W, default 9: transfer-length width in words, so lengths 0..256 are legal.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: request a copy; sampled only in IDLE.
REQ-007 The block SHALL have ports src_addr and dst_addr, input, ADDR_W bits each: byte start addresses, which must be even.
REQ-008 The block SHALL have port len, input, LEN_W bits: number of words to copy.
REQ-009 The block SHALL have port abort, input, 1 bit: cancel the copy in progress.
REQ-010 The block SHALL have port busy, output, 1 bit: high in READ and WRITE.
REQ-011 The block SHALL have ports done and err, output, 1 bit each: single-cycle completion and misalignment pulses.
REQ-012 The block SHALL have port mem_access_addr, output, ADDR_W bits: memory byte address.
REQ-013 The block SHALL have port mem_write_data, output, DATA_W bits: memory write data.
REQ-014 The block SHALL have ports mem_read and mem_write_en, output, 1 bit each: memory read and write strobes.
REQ-015 The block SHALL have port mem_read_data, input, DATA_W bits: combinational read data, valid in the same cycle mem_read is high.

Function
REQ-016 The block SHALL implement states IDLE, READ, WRITE and DONE, with all outputs decoded from registered state and registers.
REQ-017 In IDLE with start=1: if src_addr[0] or dst_addr[0] is 1, the block SHALL pulse err for one cycle, stay in IDLE and make no memory access.
REQ-018 In IDLE with start=1, aligned addresses and len=0, the block SHALL go to DONE with no memory access.
REQ-019 Otherwise, on start, the block SHALL latch the source pointer, destination pointer and remaining count, then go to READ.
REQ-020 In READ, the block SHALL drive mem_read=1 and mem_access_addr=src pointer, and capture mem_read_data into the data register at the clock edge; next state WRITE.
REQ-021 In WRITE, the block SHALL drive mem_write_en=1, mem_access_addr=dst pointer and mem_write_data=data register, then step both pointers by 2 and decrement the count.
REQ-022 After WRITE, the block SHALL go to READ if the count is still nonzero, else to DONE.
REQ-023 Throughput SHALL be 2 cycles per word; for a start accepted at cycle 0 with len=N, done SHALL be high at cycle 2N+1.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE; start SHALL be ignored while not in IDLE.
REQ-025 Pointer arithmetic SHALL be modulo 2^ADDR_W, so 0xFFFE+2 wraps to 0x0000.
REQ-026 abort=1 in READ or WRITE SHALL force IDLE at the next edge; an abort in WRITE SHALL still let that cycle's write occur, and done SHALL NOT pulse.
REQ-027 Outside READ and WRITE, mem_read, mem_write_en, mem_access_addr and mem_write_data SHALL all be 0.

Reset
REQ-028 While rst=1, the block SHALL be in IDLE with busy, done, err, mem_read and mem_write_en at 0, address and data outputs at 0, and pointers and count cleared.
REQ-029 A reset asserted mid-copy SHALL drop all strobes asynchronously, and no further access SHALL occur.

Configuration
REQ-030 With DMA_COPY_OVERLAP_EN defined, when dst_addr > src_addr and dst_addr < src_addr+2*len, the block SHALL start both pointers at base+2*(len-1) and step them by -2 (memmove semantics).
REQ-031 Without DMA_COPY_OVERLAP_EN, the block SHALL always copy in ascending address order.

Structure
REQ-032 Package dma_pkg SHALL hold the state enum, the word stride constant (2) and the alignment-check function.
REQ-033 Pointer/count update SHALL live in one sub-module, dma_addr_gen, with load, step and direction inputs; the FSM stays in dma_copy_engine.

Verification
REQ-034 Memory model of 256 words indexed by addr[8:1]: preload 0x0010..0x0016 with A1,B2,C3,D4; start src=0x0010 dst=0x0040 len=4 -> 0x0040..0x0046 hold A1,B2,C3,D4 and done at cycle 9.
REQ-035 Start with src=0x0011 -> err pulse, no strobe, busy stays 0; start with len=0 -> done at cycle 1, no strobe.
REQ-036 src=0xFFFE dst=0x0100 len=2 -> second read address is 0x0000.
REQ-037 abort asserted in the second WRITE of a len=4 copy -> exactly 2 words written, no done, IDLE next cycle.
REQ-038 With the macro: src=0x0010 dst=0x0012 len=3 -> descending copy and destination equals the original source; without it, ascending smear is checked.
REQ-039 rst pulsed during READ -> strobes 0 immediately, and the next start behaves normally.
